// File: rtl/display_scanner.sv
// Time-multiplexed scanner for a bank of common-anode 7-segment digits.
// Presents one nibble per slot to a registered hex converter and drives aligned active-low enables.
module display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] valor,
    input  logic                    blank_zeros,
    output logic [3:0]              dado,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_start
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        index;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pending_valid;
    logic                    tick;
    logic                    wrap;
    logic [NUM_DIGITS-1:0]   lit;
    logic [NUM_DIGITS-1:0]   en_next;

    assign tick = (prescaler == LAST_PRE);
    assign wrap = tick && (index == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
        end else if (wrap) begin
            index <= '0;
        end else if (tick) begin
            index <= index + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
        end
    end

    // Shadow only moves at the frame boundary so a frame is never a mix of two values.
    // A load in the wrap cycle lands in pending and waits for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (wrap && pending_valid) begin
                shadow        <= pending;
                pending_valid <= 1'b0;
            end
            if (load) begin
                pending       <= valor;
                pending_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        dado = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == IDX_W'(i)) begin
                dado = shadow[4*i +: 4];
            end
        end
    end

    // Walk down from the most significant digit; a digit stays dark while everything
    // at and above it is zero. Digit 0 always lights so a zero value still shows "0".
    always_comb begin
        logic all_zero_above;
        all_zero_above = 1'b1;
        lit            = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero_above = all_zero_above && (shadow[4*i +: 4] == 4'h0);
            if (i != 0) begin
                lit[i] = !(blank_zeros && all_zero_above);
            end
        end
    end

    always_comb begin
        en_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((index == IDX_W'(i)) && lit[i]) begin
                en_next[i] = 1'b0;
            end
        end
    end

    // One-cycle delay matches the converter's output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_en <= '1;
        end else begin
            digit_en <= en_next;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner with a behavioural frame model and a registered converter model.
module tb_display_scanner;

    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int FR  = ND * DIV;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [15:0]   valor;
    logic          blank_zeros;
    logic [3:0]    dado;
    logic [ND-1:0] digit_en;
    logic          frame_start;
    logic [6:0]    z;

    int tests_run    = 0;
    int tests_failed = 0;

    display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .valor(valor),
        .blank_zeros(blank_zeros), .dado(dado), .digit_en(digit_en),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Registered hex converter sitting downstream of dado.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) z <= 7'h7F;
        else        z <= seg7(dado);
    end

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        return v[4*i +: 4];
    endfunction

    function automatic logic [ND-1:0] model_en(input logic [15:0] v, input int idx, input logic bz);
        int hi;
        logic [ND-1:0] e;
        hi = 0;
        for (int i = 0; i < ND; i++) if (nib(v, i) != 4'h0) hi = i;
        e = '1;
        if (!bz || idx <= hi) e[idx] = 1'b0;
        return e;
    endfunction

    // Reference model: time since reset determines the slot; values move at frame boundaries.
    int            m_t;
    int            m_idx;
    logic [15:0]   m_shadow;
    logic [15:0]   m_pend;
    logic          m_pv;
    logic [ND-1:0] m_en;
    logic [ND-1:0] m_en_nxt;
    logic          m_fs;
    logic          m_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t = 0; m_idx = 0; m_shadow = '0; m_pend = '0; m_pv = 1'b0;
            m_en = '1; m_fs = 1'b0;
        end else begin
            m_en_nxt = model_en(m_shadow, m_idx, blank_zeros);
            m_wrap   = ((m_t + 1) % FR) == 0;
            if (m_wrap && m_pv) begin
                m_shadow = m_pend;
                m_pv     = 1'b0;
            end
            if (load) begin
                m_pend = valor;
                m_pv   = 1'b1;
            end
            m_fs  = m_wrap;
            m_t   = m_t + 1;
            m_idx = (m_t / DIV) % ND;
            m_en  = m_en_nxt;
        end
    end

    task automatic test_reset();
        int fs_count;
        int first_fs;
        rst_n = 1'b0; load = 1'b0; valor = '0; blank_zeros = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (digit_en !== 4'b1111) begin tests_failed++; $display("FAIL reset_en got=%b exp=1111", digit_en); end
        tests_run++;
        if (dado !== 4'h0) begin tests_failed++; $display("FAIL reset_dado got=%h exp=0", dado); end
        tests_run++;
        if (frame_start !== 1'b0) begin tests_failed++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        rst_n = 1'b1;
        fs_count = 0;
        first_fs = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            tests_run++;
            if (dado !== nib(m_shadow, m_idx) || digit_en !== m_en || frame_start !== m_fs) begin
                tests_failed++;
                $display("FAIL reset_model t=%0t dado=%h/%h en=%b/%b fs=%b/%b", $time, dado, nib(m_shadow, m_idx), digit_en, m_en, frame_start, m_fs);
            end
            if (frame_start === 1'b1) begin
                fs_count++;
                if (first_fs < 0) first_fs = k;
            end
            if (k == 5) begin
                tests_run++;
                if (digit_en !== 4'b1101) begin tests_failed++; $display("FAIL slot1_en got=%b exp=1101", digit_en); end
            end
        end
        tests_run++;
        if (first_fs != 16 || fs_count != 2) begin
            tests_failed++;
            $display("FAIL frame_period first=%0d count=%0d exp first=16 count=2", first_fs, fs_count);
        end
    endtask

    task automatic test_load_digits();
        logic [15:0] v;
        bit found;
        v = 16'h1A3F;
        @(negedge clk); load = 1'b1; valor = v;
        @(negedge clk); load = 1'b0;
        found = 0;
        for (int k = 0; k < 2 * FR && !found; k++) begin
            if (frame_start === 1'b1) found = 1;
            else @(negedge clk);
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL load_wait got=timeout exp=frame_start"); end
        for (int k = 0; k <= FR; k++) begin
            if (k < FR) begin
                tests_run++;
                if (dado !== nib(v, k / DIV)) begin
                    tests_failed++; $display("FAIL load_dado k=%0d got=%h exp=%h", k, dado, nib(v, k / DIV));
                end
            end
            if (k >= 1) begin
                tests_run++;
                if (digit_en !== ~(4'b0001 << ((k - 1) / DIV))) begin
                    tests_failed++; $display("FAIL load_en k=%0d got=%b exp=%b", k, digit_en, ~(4'b0001 << ((k - 1) / DIV)));
                end
                tests_run++;
                if (z !== seg7(nib(v, (k - 1) / DIV))) begin
                    tests_failed++; $display("FAIL align_z k=%0d en=%b got=%b exp=%b", k, digit_en, z, seg7(nib(v, (k - 1) / DIV)));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blank();
        logic [15:0] vals [2];
        logic [ND-1:0] exp_en;
        bit found;
        int fs_seen;
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        blank_zeros = 1'b1;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk); load = 1'b1; valor = vals[p];
            @(negedge clk); load = 1'b0;
            found = 0;
            fs_seen = 0;
            for (int k = 0; k < 3 * FR && !found; k++) begin
                tests_run++;
                if (dado !== nib(m_shadow, m_idx) || digit_en !== m_en || frame_start !== m_fs) begin
                    tests_failed++;
                    $display("FAIL blank_model t=%0t dado=%h/%h en=%b/%b fs=%b/%b", $time, dado, nib(m_shadow, m_idx), digit_en, m_en, frame_start, m_fs);
                end
                if (frame_start === 1'b1) fs_seen++;
                if (fs_seen == 2) found = 1;
                else @(negedge clk);
            end
            tests_run++;
            if (!found) begin tests_failed++; $display("FAIL blank_wait p=%0d got=timeout exp=frame_start", p); end
            for (int k = 1; k <= FR; k++) begin
                @(negedge clk);
                if (p == 0) exp_en = ((k - 1) / DIV == 0) ? 4'b1110 : ((k - 1) / DIV == 1) ? 4'b1101 : 4'b1111;
                else        exp_en = ((k - 1) / DIV == 0) ? 4'b1110 : 4'b1111;
                tests_run++;
                if (digit_en !== exp_en) begin
                    tests_failed++; $display("FAIL blank_en p=%0d k=%0d got=%b exp=%b", p, k, digit_en, exp_en);
                end
                if (p == 1 && digit_en === 4'b1110) begin
                    tests_run++;
                    if (z !== 7'b1000000) begin tests_failed++; $display("FAIL zero_z got=%b exp=1000000", z); end
                end
            end
        end
        blank_zeros = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit found;
        int bad1;
        int bad2;
        found = 0;
        for (int k = 0; k < 2 * FR && !found; k++) begin
            @(negedge clk);
            if (((m_t + 1) % FR) == 8) found = 1;
        end
        load = 1'b1; valor = 16'h1111;
        @(negedge clk); load = 1'b0;
        found = 0;
        for (int k = 0; k < 2 * FR && !found; k++) begin
            if (((m_t + 1) % FR) == 0) found = 1;
            else @(negedge clk);
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL tear_wait got=timeout exp=wrap_cycle"); end
        load = 1'b1; valor = 16'h2222;
        @(negedge clk); load = 1'b0;
        tests_run++;
        if (frame_start !== 1'b1) begin tests_failed++; $display("FAIL tear_fs got=%b exp=1", frame_start); end
        bad1 = 0;
        bad2 = 0;
        for (int k = 0; k < 2 * FR; k++) begin
            if (k < FR && dado !== 4'h1) bad1++;
            if (k >= FR && dado !== 4'h2) bad2++;
            tests_run++;
            if (dado !== nib(m_shadow, m_idx) || digit_en !== m_en || frame_start !== m_fs) begin
                tests_failed++;
                $display("FAIL tear_model t=%0t dado=%h/%h en=%b/%b fs=%b/%b", $time, dado, nib(m_shadow, m_idx), digit_en, m_en, frame_start, m_fs);
            end
            @(negedge clk);
        end
        tests_run++;
        if (bad1 != 0 || bad2 != 0) begin
            tests_failed++; $display("FAIL tear_frames got bad1=%0d bad2=%0d exp 0 0", bad1, bad2);
        end
    endtask

    task automatic test_random();
        logic [15:0] masks [5];
        masks[0] = 16'hFFFF; masks[1] = 16'h0FFF; masks[2] = 16'h00FF;
        masks[3] = 16'h000F; masks[4] = 16'h0000;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            tests_run++;
            if (dado !== nib(m_shadow, m_idx) || digit_en !== m_en || frame_start !== m_fs) begin
                tests_failed++;
                $display("FAIL rand_model t=%0t dado=%h/%h en=%b/%b fs=%b/%b", $time, dado, nib(m_shadow, m_idx), digit_en, m_en, frame_start, m_fs);
            end
            load  = ($urandom_range(0, 7) == 0);
            valor = 16'($urandom) & masks[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0) blank_zeros = ~blank_zeros;
        end
        load = 1'b0;
        blank_zeros = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        int nonzero;
        @(negedge clk); load = 1'b1; valor = 16'hBEEF;
        @(negedge clk); load = 1'b0;
        found = 0;
        for (int k = 0; k < 2 * FR && !found; k++) begin
            if (frame_start === 1'b1) found = 1;
            else @(negedge clk);
        end
        load = 1'b1; valor = 16'h1234;
        @(negedge clk); load = 1'b0;
        found = 0;
        for (int k = 0; k < 2 * FR && !found; k++) begin
            if (m_idx == 2 && (m_t % DIV) == 1) found = 1;
            else @(negedge clk);
        end
        tests_run++;
        if (!found || dado !== 4'hE) begin
            tests_failed++; $display("FAIL rst_mid_pre found=%0d got=%h exp=e", found, dado);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (digit_en !== 4'b1111 || dado !== 4'h0 || frame_start !== 1'b0) begin
            tests_failed++; $display("FAIL rst_async got en=%b dado=%h fs=%b exp 1111 0 0", digit_en, dado, frame_start);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nonzero = 0;
        for (int k = 0; k < 3 * FR; k++) begin
            @(negedge clk);
            if (dado !== 4'h0) nonzero++;
            tests_run++;
            if (dado !== nib(m_shadow, m_idx) || digit_en !== m_en || frame_start !== m_fs) begin
                tests_failed++;
                $display("FAIL rst_mid_model t=%0t dado=%h/%h en=%b/%b fs=%b/%b", $time, dado, nib(m_shadow, m_idx), digit_en, m_en, frame_start, m_fs);
            end
        end
        tests_run++;
        if (nonzero != 0) begin tests_failed++; $display("FAIL rst_pending_lost got=%0d nonzero slots exp=0", nonzero); end
    endtask

    initial begin
        test_reset();
        test_load_digits();
        test_blank();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
